// File: rtl/water_flow_pkg.sv
// ============================================================================
// Module : water_flow_pkg
// Brief  : Shared defaults and mode encoding for the water flow monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package water_flow_pkg;

    localparam int DEFAULT_LEVEL_W    = 10;
    localparam int DEFAULT_THRESHOLD  = 10;
    localparam int DEFAULT_TIME_LIMIT = 10;

    typedef enum logic {
        MODE_DRAIN = 1'b0,
        MODE_FILL  = 1'b1
    } mode_t;

endpackage : water_flow_pkg

`default_nettype wire

// File: rtl/level_delta_checker.sv
// ============================================================================
// Module : level_delta_checker
// Brief  : Combinational progress detector comparing two level samples.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_delta_checker
    import water_flow_pkg::*;
#(
    parameter int LEVEL_W   = DEFAULT_LEVEL_W,
    parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
    input  logic [LEVEL_W-1:0] current_level,
    input  logic [LEVEL_W-1:0] previous_level,
    input  mode_t              mode,
    output logic               progress
);

    localparam logic [LEVEL_W-1:0] c_threshold = LEVEL_W'(THRESHOLD);

    logic [LEVEL_W-1:0] w_rise;
    logic [LEVEL_W-1:0] w_fall;
    logic               w_fill_ok;
    logic               w_drain_ok;

    // Each subtraction is only trusted when its direction guard holds.
    assign w_rise     = current_level - previous_level;
    assign w_fall     = previous_level - current_level;
    assign w_fill_ok  = (current_level > previous_level) && (w_rise >= c_threshold);
    assign w_drain_ok = (previous_level > current_level) && (w_fall >= c_threshold);

    assign progress = (mode == MODE_FILL) ? w_fill_ok : w_drain_ok;

endmodule : level_delta_checker

`default_nettype wire

// File: rtl/water_flow_monitor.sv
// ============================================================================
// Module : water_flow_monitor
// Brief  : Flags a flow fault after TIME_LIMIT consecutive no-progress samples.
//          Define WFM_STICKY_ERROR_EN to hold error_flag until reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module water_flow_monitor
    import water_flow_pkg::*;
#(
    parameter int LEVEL_W    = DEFAULT_LEVEL_W,
    parameter int THRESHOLD  = DEFAULT_THRESHOLD,
    parameter int TIME_LIMIT = DEFAULT_TIME_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    input  logic               mode,
    output logic               error_flag
);

    localparam int                   CNT_W        = $clog2(TIME_LIMIT + 1);
    localparam logic [CNT_W-1:0]     c_time_limit = CNT_W'(TIME_LIMIT);
    localparam logic [CNT_W-1:0]     c_cnt_one    = CNT_W'(1);

    logic [LEVEL_W-1:0] r_previous_level;
    logic [CNT_W-1:0]   r_counter;
    logic               r_error_flag;
    mode_t              r_prev_mode;

    mode_t              w_mode;
    logic               w_progress;
    logic [CNT_W-1:0]   w_counter_inc;

    assign w_mode        = mode_t'(mode);
    assign w_counter_inc = r_counter + c_cnt_one;

    level_delta_checker #(
        .LEVEL_W   (LEVEL_W),
        .THRESHOLD (THRESHOLD)
    ) u_level_delta_checker (
        .current_level  (water_level_sensor),
        .previous_level (r_previous_level),
        .mode           (w_mode),
        .progress       (w_progress)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_previous_level <= water_level_sensor;
            r_prev_mode      <= w_mode;
            r_counter        <= '0;
            r_error_flag     <= 1'b0;
        end else begin
            r_previous_level <= water_level_sensor;
            r_prev_mode      <= w_mode;
            // A mode switch restarts the stall window without judging progress.
            if (w_mode != r_prev_mode) begin
                r_counter <= '0;
            end else if (w_progress) begin
                r_counter <= '0;
`ifdef WFM_STICKY_ERROR_EN
`else
                r_error_flag <= 1'b0;
`endif
            end else if (r_counter != c_time_limit) begin
                r_counter <= w_counter_inc;
                if (w_counter_inc == c_time_limit) begin
                    r_error_flag <= 1'b1;
                end
            end
        end
    end

    assign error_flag = r_error_flag;

endmodule : water_flow_monitor

`default_nettype wire

// File: tb/tb_water_flow_monitor.sv
// ============================================================================
// Module : tb_water_flow_monitor
// Brief  : Directed self-checking bench for water_flow_monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_water_flow_monitor;

    logic       clk;
    logic       reset;
    logic [9:0] water_level_sensor;
    logic       mode;
    logic       error_flag;

    int checks;
    int failures;

    water_flow_monitor dut (
        .clk                (clk),
        .reset              (reset),
        .water_level_sensor (water_level_sensor),
        .mode               (mode),
        .error_flag         (error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, observe 1 time unit after the rising edge.
    task automatic step(input int level, input logic m, input logic rst);
        @(negedge clk);
        water_level_sensor = 10'(level);
        mode               = m;
        reset              = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(50, 1'b1, 1'b1);
        checks++;
        if (error_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b want=0", error_flag);
        end
        checks++;
        if (dut.r_counter !== 4'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d want=0", dut.r_counter);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 5; i++) begin
            step(50 + 20 * i, 1'b1, 1'b0);
            checks++;
            if (error_flag !== 1'b0 || dut.r_counter !== 4'd0) begin
                failures++;
                $display("FAIL fill_rise[%0d] got err=%b cnt=%0d want err=0 cnt=0", i, error_flag, dut.r_counter);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            step(150, 1'b1, 1'b0);
            checks++;
            if (dut.r_counter !== 4'((i > 10) ? 10 : i) || error_flag !== (i >= 10)) begin
                failures++;
                $display("FAIL fill_stall[%0d] got err=%b cnt=%0d want err=%b cnt=%0d",
                         i, error_flag, dut.r_counter, (i >= 10), (i > 10) ? 10 : i);
            end
        end
    endtask

    task automatic test_drain;
        step(200, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(200 - 20 * i, 1'b0, 1'b0);
            checks++;
            if (error_flag !== 1'b0 || dut.r_counter !== 4'd0) begin
                failures++;
                $display("FAIL drain_fall[%0d] got err=%b cnt=%0d want err=0 cnt=0", i, error_flag, dut.r_counter);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            step(100, 1'b0, 1'b0);
            checks++;
            if (error_flag !== (i == 10)) begin
                failures++;
                $display("FAIL drain_hold[%0d] got err=%b want=%b", i, error_flag, (i == 10));
            end
        end
    endtask

    task automatic test_slow_fill;
        step(50, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(50 + 5 * i, 1'b1, 1'b0);
            checks++;
            if (error_flag !== (i == 10) || dut.r_counter !== 4'(i)) begin
                failures++;
                $display("FAIL slow_fill[%0d] got err=%b cnt=%0d want err=%b cnt=%0d",
                         i, error_flag, dut.r_counter, (i == 10), i);
            end
        end
        step(50, 1'b1, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step(50 + 10 * i, 1'b1, 1'b0);
            checks++;
            if (error_flag !== 1'b0 || dut.r_counter !== 4'd0) begin
                failures++;
                $display("FAIL exact_threshold[%0d] got err=%b cnt=%0d want err=0 cnt=0", i, error_flag, dut.r_counter);
            end
        end
    endtask

    task automatic test_wrong_dir_mode_change;
        int exp_cnt [6] = '{1, 2, 3, 0, 0, 1};
        int levels  [6] = '{480, 460, 440, 420, 400, 391};
        logic modes [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        step(500, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(levels[i], modes[i], 1'b0);
            checks++;
            if (dut.r_counter !== 4'(exp_cnt[i]) || error_flag !== 1'b0) begin
                failures++;
                $display("FAIL wrong_dir_mode[%0d] got cnt=%0d err=%b want cnt=%0d err=0",
                         i, dut.r_counter, error_flag, exp_cnt[i]);
            end
        end
        step(381, 1'b0, 1'b0);
        checks++;
        if (dut.r_counter !== 4'd0) begin
            failures++;
            $display("FAIL drain_exact_threshold got cnt=%0d want=0", dut.r_counter);
        end
    endtask

    task automatic test_error_clear;
        step(50, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(50, 1'b1, 1'b0);
        checks++;
        if (error_flag !== 1'b1) begin
            failures++;
            $display("FAIL clear_setup got err=%b want=1", error_flag);
        end
        step(70, 1'b1, 1'b0);
        checks++;
`ifdef WFM_STICKY_ERROR_EN
        if (error_flag !== 1'b1 || dut.r_counter !== 4'd0) begin
            failures++;
            $display("FAIL sticky_hold got err=%b cnt=%0d want err=1 cnt=0", error_flag, dut.r_counter);
        end
`else
        if (error_flag !== 1'b0 || dut.r_counter !== 4'd0) begin
            failures++;
            $display("FAIL nonsticky_clear got err=%b cnt=%0d want err=0 cnt=0", error_flag, dut.r_counter);
        end
`endif
    endtask

    task automatic test_reset_priority;
        step(300, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(300, 1'b1, 1'b0);
        // Progress-sized jump while reset is high must still clear everything.
        step(400, 1'b1, 1'b1);
        checks++;
        if (error_flag !== 1'b0 || dut.r_counter !== 4'd0) begin
            failures++;
            $display("FAIL reset_priority got err=%b cnt=%0d want err=0 cnt=0", error_flag, dut.r_counter);
        end
        step(400, 1'b1, 1'b0);
        checks++;
        if (dut.r_counter !== 4'd1) begin
            failures++;
            $display("FAIL reset_reload got cnt=%0d want=1", dut.r_counter);
        end
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        reset              = 1'b1;
        mode               = 1'b1;
        water_level_sensor = '0;
        test_reset;
        test_fill;
        test_drain;
        test_slow_fill;
        test_wrong_dir_mode_change;
        test_error_clear;
        test_reset_priority;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_water_flow_monitor

`default_nettype wire
